fb_pixel_writer: RTL and testbench

Consumer end of the line-generator pixel stream. Accepts {x,y} pixel addresses from the Bresenham line generator, range-checks them, converts them to linear 640x480 frame-buffer addresses, and queues them in a small FIFO. Drains the queue to frame-buffer SRAM through a hold-until-ack write handshake. Drives `stop` back to the generator as backpressure and signals when a line has been completely committed to memory.

---
 rtl/fb_pixel_writer.sv | 135 +++++++++++++
 tb/tb_fb_pixel_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// Pixel sink for the line generator: range-checks {x,y}, converts to a linear
// 640x480 address, queues in a show-ahead FIFO and drains with hold-until-ack writes.
module fb_pixel_writer #(
  parameter int DEPTH   = 4,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [18:0]        pix_address,
  input  logic               pix_valid,
  input  logic [COLOR_W-1:0] color,
  input  logic               line_done,
  output logic               stop,
  output logic [18:0]        mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_wen,
  input  logic               mem_ack,
  output logic               frame_done,
  output logic               overflow,
  output logic [7:0]         drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state_q;
  logic               frame_done_q;
  logic               stop_q;
  logic               overflow_q;
  logic [7:0]         drop_q;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;

  logic [18:0]        addr_mem [DEPTH];
  logic [COLOR_W-1:0] data_mem [DEPTH];

  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        in_range;
  logic [18:0] lin_addr;
  logic        empty, full, push, pop, lost;

  assign pix_x    = pix_address[18:9];
  assign pix_y    = pix_address[8:0];
  assign in_range = (pix_x < 10'd640) && (pix_y < 9'd480);
  // y*640 = y*512 + y*128; the largest result (307199) fits in 19 bits
  assign lin_addr = ({10'd0, pix_y} << 9) + ({10'd0, pix_y} << 7) + {9'd0, pix_x};

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = !empty && mem_ack;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push  = pix_valid && in_range && (!full || pop);
  assign lost  = pix_valid && in_range && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (!push && pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= lin_addr;
      data_mem[wr_ptr_q] <= color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      count_q <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      stop_q <= (count_d >= CW'(DEPTH - 1));
      if (lost)
        overflow_q <= 1'b1;
      if (pix_valid && !in_range && (drop_q != 8'hFF))
        drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (line_done)
            state_q <= FLUSH;
          else if (pix_valid)
            state_q <= RUN;
        end
        RUN: begin
          if (line_done)
            state_q <= FLUSH;
        end
        FLUSH: begin
          if (empty) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= pix_valid ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Head entry is gated so the bus reads zero whenever nothing is queued.
  assign mem_wen    = !empty;
  assign mem_addr   = empty ? 19'd0 : addr_mem[rd_ptr_q];
  assign mem_wdata  = empty ? '0 : data_mem[rd_ptr_q];
  assign stop       = stop_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: hand-computed expectations checked with
// immediate assertions, plus a log of every acknowledged write.
module tb_fb_pixel_writer;

  logic        clk;
  logic        rst;
  logic [18:0] pix_address;
  logic        pix_valid;
  logic [7:0]  color;
  logic        line_done;
  logic        stop;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        mem_ack;
  logic        frame_done;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks   = 0;
  int failures = 0;
  int wlog[$];

  fb_pixel_writer #(.DEPTH(4), .COLOR_W(8)) dut (
    .clk(clk), .rst(rst), .pix_address(pix_address), .pix_valid(pix_valid),
    .color(color), .line_done(line_done), .stop(stop), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ack(mem_ack),
    .frame_done(frame_done), .overflow(overflow), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_wen && mem_ack)
      wlog.push_back(int'(mem_addr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] pix(input int x, input int y);
    logic [9:0] xv;
    logic [8:0] yv;
    xv = 10'(x);
    yv = 9'(y);
    return {xv, yv};
  endfunction

  initial begin
    int sent;
    bit prev_stop, cur_stop, seen_stop;

    rst = 1'b1; pix_address = '0; pix_valid = 1'b0; color = 8'h5A;
    line_done = 1'b0; mem_ack = 1'b0;
    #2;
    chk("rst_stop", int'(stop), 0);
    chk("rst_wen", int'(mem_wen), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop", int'(drop_count), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single pixel (3,2)
    mem_ack = 1'b1; wlog.delete();
    pix_address = pix(3, 2); pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    chk("single_wen", int'(mem_wen), 1);
    chk("single_addr", int'(mem_addr), 1283);
    chk("single_wdata", int'(mem_wdata), 8'h5A);
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
    chk("single_drained", int'(mem_wen), 0);
    chk("single_fd_early", int'(frame_done), 0);
    tick();
    chk("single_fd_pulse", int'(frame_done), 1);
    tick();
    chk("single_fd_end", int'(frame_done), 0);
    chk("single_nwrites", wlog.size(), 1);
    if (wlog.size() >= 1) chk("single_log_addr", wlog[0], 1283);

    // Stalled burst with a generator that reacts to stop one cycle late
    wlog.delete(); sent = 0; prev_stop = 1'b0; seen_stop = 1'b0;
    for (int c = 0; c < 30; c++) begin
      mem_ack = (c >= 8);
      if (sent < 8 && !prev_stop) begin
        pix_valid = 1'b1; pix_address = pix(sent, 0);
      end else begin
        pix_valid = 1'b0;
      end
      cur_stop = stop;
      tick();
      if (pix_valid) sent++;
      prev_stop = cur_stop;
      if (stop && !seen_stop) begin
        seen_stop = 1'b1;
        chk("burst_stop_at_occ3", sent, 3);
      end
      if (c == 7) begin
        chk("burst_stall_wen", int'(mem_wen), 1);
        chk("burst_stall_addr", int'(mem_addr), 0);
        chk("burst_stall_stop", int'(stop), 1);
      end
    end
    pix_valid = 1'b0;
    chk("burst_stop_seen", int'(seen_stop), 1);
    chk("burst_overflow", int'(overflow), 0);
    chk("burst_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      chk($sformatf("burst_order_%0d", i), wlog[i], i);
    chk("burst_stop_low", int'(stop), 0);

    // Out-of-range pixels
    wlog.delete(); mem_ack = 1'b1;
    pix_address = pix(640, 0); pix_valid = 1'b1;
    tick();
    chk("oor_x_wen", int'(mem_wen), 0);
    pix_address = pix(0, 480);
    tick();
    pix_valid = 1'b0;
    chk("oor_y_wen", int'(mem_wen), 0);
    chk("oor_drop2", int'(drop_count), 2);
    pix_address = pix(700, 5); pix_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    pix_valid = 1'b0;
    tick();
    chk("oor_drop_sat", int'(drop_count), 255);
    chk("oor_nwrites", wlog.size(), 0);

    // Corner pixels
    mem_ack = 1'b0;
    pix_address = pix(639, 479); pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    chk("corner_max_wen", int'(mem_wen), 1);
    chk("corner_max_addr", int'(mem_addr), 307199);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    pix_address = pix(0, 0); pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    chk("corner_zero_wen", int'(mem_wen), 1);
    chk("corner_zero_addr", int'(mem_addr), 0);
    mem_ack = 1'b1;
    tick();
    chk("corner_nwrites", wlog.size(), 2);
    if (wlog.size() >= 1) chk("corner_log0", wlog[0], 307199);

    // Full FIFO: push+pop while full, then a lost pixel
    wlog.delete(); mem_ack = 1'b0;
    for (int i = 10; i < 14; i++) begin
      pix_address = pix(i, 0); pix_valid = 1'b1;
      tick();
    end
    pix_address = pix(14, 0); mem_ack = 1'b1;
    tick();
    chk("full_pp_overflow", int'(overflow), 0);
    chk("full_pp_head", int'(mem_addr), 11);
    chk("full_pp_stop", int'(stop), 1);
    pix_address = pix(15, 0); mem_ack = 1'b0;
    tick();
    pix_valid = 1'b0;
    chk("full_lost_overflow", int'(overflow), 1);
    chk("full_lost_head", int'(mem_addr), 11);
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("full_drained", int'(mem_wen), 0);
    chk("full_sticky", int'(overflow), 1);
    chk("full_nwrites", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      chk($sformatf("full_order_%0d", i), wlog[i], 10 + i);

    // Reset mid-operation with three entries queued
    mem_ack = 1'b0;
    for (int i = 20; i < 23; i++) begin
      pix_address = pix(i, 0); pix_valid = 1'b1;
      tick();
    end
    pix_valid = 1'b0;
    chk("mid_pre_wen", int'(mem_wen), 1);
    chk("mid_pre_stop", int'(stop), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_wen", int'(mem_wen), 0);
    chk("mid_async_stop", int'(stop), 0);
    chk("mid_async_overflow", int'(overflow), 0);
    chk("mid_async_drop", int'(drop_count), 0);
    tick();
    rst = 1'b0; mem_ack = 1'b1; wlog.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("mid_no_stale", wlog.size(), 0);
    chk("mid_wen_idle", int'(mem_wen), 0);
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
    chk("mid_fd_early", int'(frame_done), 0);
    tick();
    chk("mid_fd_pulse", int'(frame_done), 1);
    tick();
    chk("mid_fd_end", int'(frame_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
